// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage and the pipeline registers
// around it: datapath/size-field widths, access-size codes, the control FSM
// state encoding and the size/alignment helper functions.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int NB_DEFAULT           = 32;
    localparam int NB_SIZE_TYPE_DEFAULT = 3;

    // One-hot access-size codes carried in the EX/MEM size field.
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    function automatic logic size_valid(input logic [2:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
    endfunction

    // Invalid size codes never report misalignment; they simply do nothing.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF: mis = lane[0];
            SIZE_WORD: mis = |lane;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational byte-lane select plus sign/zero extension for loads.
// Ports:
//   word      in  NB            full memory word (little-endian lanes)
//   lane      in  2             byte lane of the access
//   size      in  NB_SIZE_TYPE  access size code (byte/half/word)
//   sign_ext  in  1             1 = sign-extend byte/half, 0 = zero-extend
//   data      out NB            aligned, extended result (0 for invalid size)
// ---------------------------------------------------------------------------
module load_align
    import mem_stage_pkg::*;
#(
    parameter int NB           = NB_DEFAULT,
    parameter int NB_SIZE_TYPE = NB_SIZE_TYPE_DEFAULT
) (
    input  logic [NB-1:0]           word,
    input  logic [1:0]              lane,
    input  logic [NB_SIZE_TYPE-1:0] size,
    input  logic                    sign_ext,
    output logic [NB-1:0]           data
);

    logic [NB-1:0] shifted;

    always_comb begin
        // Bring the addressed lane down to bit 0 before extension.
        shifted = word >> {lane, 3'b000};
        data    = '0;
        case (size)
            SIZE_BYTE: data = {{(NB-8){sign_ext & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = {{(NB-16){sign_ext & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the pipelined MIPS core. Owns the byte-addressed
// data memory (2^NB_ADDR words), serves byte/half/word loads combinationally
// and commits stores at posedge. A control FSM clears the memory after reset
// (CLEAR), serves the pipeline (IDLE) and streams every word to the debug
// unit (DUMP).
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_step                  pipeline advance enable (gates store commit)
//   i_alu_result            byte address
//   i_data_b_to_write       store data
//   i_mem_read/i_mem_write  load/store request
//   i_signed                sign-extend byte/half loads
//   i_word_size             access size code
//   i_dump_req              start a memory dump (honoured only in IDLE)
//   i_dump_ready            dump consumer ready
//   o_read_data             load result
//   o_misaligned            current access is misaligned
//   o_busy                  FSM not in IDLE
//   o_dump_data/o_dump_addr registered dump word and its word index
//   o_dump_valid            dump word valid
//   o_dump_done             one-cycle pulse after the last beat
// Dump handshake: a beat transfers on a posedge where o_dump_valid and
// i_dump_ready are both high; while valid is high and ready is low,
// o_dump_data and o_dump_addr hold their values.
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB           = NB_DEFAULT,
    parameter int NB_SIZE_TYPE = NB_SIZE_TYPE_DEFAULT,
    parameter int NB_ADDR      = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic [NB-1:0]           i_alu_result,
    input  logic [NB-1:0]           i_data_b_to_write,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_signed,
    input  logic [NB_SIZE_TYPE-1:0] i_word_size,
    input  logic                    i_dump_req,
    input  logic                    i_dump_ready,
    output logic [NB-1:0]           o_read_data,
    output logic                    o_misaligned,
    output logic                    o_busy,
    output logic [NB-1:0]           o_dump_data,
    output logic [NB_ADDR-1:0]      o_dump_addr,
    output logic                    o_dump_valid,
    output logic                    o_dump_done
);

    localparam int                 DEPTH    = 1 << NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_IDX = '1;

    logic [NB-1:0]      mem [DEPTH];
    state_t             state;
    logic [NB_ADDR-1:0] clear_cnt;
    logic [NB_ADDR-1:0] dump_next;

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         lane;
    logic               unused_upper_addr;
    logic               size_ok;
    logic               access_misaligned;
    logic               store_en;
    logic [NB-1:0]      wr_mask;
    logic [NB-1:0]      wr_data;
    logic [NB-1:0]      aligned_data;

    // Address bits above the memory depth are ignored, so addresses wrap.
    assign word_idx          = i_alu_result[NB_ADDR+1:2];
    assign lane              = i_alu_result[1:0];
    assign unused_upper_addr = ^i_alu_result[NB-1:NB_ADDR+2];

    assign size_ok           = size_valid(i_word_size);
    assign access_misaligned = is_misaligned(i_word_size, lane);
    assign o_misaligned      = (i_mem_read | i_mem_write) & access_misaligned;
    assign o_busy            = (state != ST_IDLE);
    assign store_en          = (state == ST_IDLE) & i_step & i_mem_write & size_ok
                               & ~access_misaligned;
    assign dump_next         = o_dump_addr + NB_ADDR'(1);

    // Store data is replicated across lanes; the mask picks the written bytes.
    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        case (i_word_size)
            SIZE_BYTE: begin
                wr_mask = NB'(8'hFF) << {lane, 3'b000};
                wr_data = {(NB/8){i_data_b_to_write[7:0]}};
            end
            SIZE_HALF: begin
                wr_mask = NB'(16'hFFFF) << {lane[1], 4'b0000};
                wr_data = {(NB/16){i_data_b_to_write[15:0]}};
            end
            SIZE_WORD: begin
                wr_mask = '1;
                wr_data = i_data_b_to_write;
            end
            default: begin
                wr_mask = '0;
                wr_data = '0;
            end
        endcase
    end

    load_align #(
        .NB           (NB),
        .NB_SIZE_TYPE (NB_SIZE_TYPE)
    ) u_load_align (
        .word     (mem[word_idx]),
        .lane     (lane),
        .size     (i_word_size),
        .sign_ext (i_signed),
        .data     (aligned_data)
    );

    assign o_read_data = (i_mem_read & size_ok & ~access_misaligned & ~o_busy)
                         ? aligned_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_CLEAR;
            clear_cnt    <= '0;
            o_dump_valid <= 1'b0;
            o_dump_done  <= 1'b0;
            o_dump_data  <= '0;
            o_dump_addr  <= '0;
        end else begin
            o_dump_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    mem[clear_cnt] <= '0;
                    clear_cnt      <= clear_cnt + NB_ADDR'(1);
                    if (clear_cnt == LAST_IDX) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (store_en) begin
                        mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (wr_data & wr_mask);
                    end
                    if (i_dump_req) begin
                        state        <= ST_DUMP;
                        o_dump_valid <= 1'b1;
                        o_dump_addr  <= '0;
                        o_dump_data  <= mem[0];
                    end
                end
                ST_DUMP: begin
                    if (o_dump_valid && i_dump_ready) begin
                        if (o_dump_addr == LAST_IDX) begin
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            o_dump_addr <= dump_next;
                            o_dump_data <= mem[dump_next];
                        end
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    clear_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: post-reset clear timing, aligned and
// misaligned loads/stores with hand-computed results, a throttled dump
// scored against a bench-side copy of memory, and reset in the middle of a
// dump.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_step;
    logic [31:0] i_alu_result;
    logic [31:0] i_data_b_to_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_signed;
    logic [2:0]  i_word_size;
    logic        i_dump_req;
    logic        i_dump_ready;
    logic [31:0] o_read_data;
    logic        o_misaligned;
    logic        o_busy;
    logic [31:0] o_dump_data;
    logic [5:0]  o_dump_addr;
    logic        o_dump_valid;
    logic        o_dump_done;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [64];
    logic [31:0] exp_q [$];

    mem_stage dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_step            (i_step),
        .i_alu_result      (i_alu_result),
        .i_data_b_to_write (i_data_b_to_write),
        .i_mem_read        (i_mem_read),
        .i_mem_write       (i_mem_write),
        .i_signed          (i_signed),
        .i_word_size       (i_word_size),
        .i_dump_req        (i_dump_req),
        .i_dump_ready      (i_dump_ready),
        .o_read_data       (o_read_data),
        .o_misaligned      (o_misaligned),
        .o_busy            (o_busy),
        .o_dump_data       (o_dump_data),
        .o_dump_addr       (o_dump_addr),
        .o_dump_valid      (o_dump_valid),
        .o_dump_done       (o_dump_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input logic [2:0] size,
                              input logic sgn, input logic [31:0] exp_data, input logic exp_mis);
        i_alu_result = addr;
        i_word_size  = size;
        i_signed     = sgn;
        i_mem_read   = 1'b1;
        #1;
        check(tag, o_read_data, exp_data);
        check({tag, "_mis"}, 32'(o_misaligned), 32'(exp_mis));
        i_mem_read = 1'b0;
        tick();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size,
                         input logic step);
        i_alu_result      = addr;
        i_data_b_to_write = data;
        i_word_size       = size;
        i_mem_write       = 1'b1;
        i_step            = step;
        tick();
        i_mem_write = 1'b0;
        i_step      = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          cnt;
        int          cyc;
        int          beats;
        int          done_cnt;
        bit          held;
        logic [31:0] held_d;
        logic [5:0]  held_a;
        logic [31:0] exp_word;

        i_reset = 1'b1; i_step = 1'b0; i_alu_result = '0; i_data_b_to_write = '0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_signed = 1'b0; i_word_size = SIZE_WORD;
        i_dump_req = 1'b0; i_dump_ready = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;

        repeat (3) tick();
        check("rst_busy",       32'(o_busy), 32'd1);
        check("rst_dump_valid", 32'(o_dump_valid), 32'd0);
        check("rst_dump_done",  32'(o_dump_done), 32'd0);
        check("rst_dump_data",  o_dump_data, 32'd0);
        check("rst_dump_addr",  32'(o_dump_addr), 32'd0);

        // Clear runs 64 cycles with i_step held low.
        i_reset = 1'b0;
        cnt = 0;
        while (o_busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("clear_len", 32'(cnt), 32'd64);
        load_check("ld_w_0x10_after_clear", 32'h10, SIZE_WORD, 1'b0, 32'h0, 1'b0);

        // Word store then sub-word loads.
        store(32'h8, 32'hDEADBEEF, SIZE_WORD, 1'b1);
        model_mem[2] = 32'hDEADBEEF;
        load_check("ld_w_0x8",       32'h8, SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
        load_check("ld_sb_0x9",      32'h9, SIZE_BYTE, 1'b1, 32'hFFFFFFBE, 1'b0);
        load_check("ld_uh_0xA",      32'hA, SIZE_HALF, 1'b0, 32'h0000DEAD, 1'b0);
        load_check("ld_sh_0xA",      32'hA, SIZE_HALF, 1'b1, 32'hFFFFDEAD, 1'b0);
        load_check("ld_ub_0xB",      32'hB, SIZE_BYTE, 1'b0, 32'h000000DE, 1'b0);
        load_check("ld_sb_0x8",      32'h8, SIZE_BYTE, 1'b1, 32'hFFFFFFEF, 1'b0);

        // Byte store preserves other lanes.
        store(32'hB, 32'h0000007F, SIZE_BYTE, 1'b1);
        model_mem[2] = 32'h7FADBEEF;
        load_check("ld_w_0x8_after_sb", 32'h8, SIZE_WORD, 1'b0, 32'h7FADBEEF, 1'b0);
        load_check("ld_sb_0xB_pos",     32'hB, SIZE_BYTE, 1'b1, 32'h0000007F, 1'b0);

        // Misaligned word store: flagged and dropped.
        i_alu_result = 32'h6; i_word_size = SIZE_WORD; i_mem_write = 1'b1;
        i_data_b_to_write = 32'h11223344;
        #1;
        check("st_w_0x6_mis", 32'(o_misaligned), 32'd1);
        store(32'h6, 32'h11223344, SIZE_WORD, 1'b1);
        load_check("ld_w_0x4_unchanged", 32'h4, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        load_check("ld_w_0x8_unchanged", 32'h8, SIZE_WORD, 1'b0, 32'h7FADBEEF, 1'b0);
        load_check("ld_h_0x5_mis",       32'h5, SIZE_HALF, 1'b0, 32'h0, 1'b1);

        // Store without step is dropped; wrapped address; half store lane 1.
        store(32'h14, 32'h55555555, SIZE_WORD, 1'b0);
        load_check("ld_w_0x14_nostep", 32'h14, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        store(32'h10C, 32'hCAFEF00D, SIZE_WORD, 1'b1);
        model_mem[3] = 32'hCAFEF00D;
        load_check("ld_w_0xC_wrap", 32'hC, SIZE_WORD, 1'b0, 32'hCAFEF00D, 1'b0);
        store(32'h12, 32'h00001234, SIZE_HALF, 1'b1);
        model_mem[4] = 32'h12340000;
        load_check("ld_w_0x10_sh", 32'h10, SIZE_WORD, 1'b0, 32'h12340000, 1'b0);

        // Invalid size and no-read cases.
        load_check("ld_bad_size", 32'h8, 3'b011, 1'b0, 32'h0, 1'b0);
        i_alu_result = 32'h8; i_word_size = SIZE_WORD; i_mem_read = 1'b0;
        #1;
        check("ld_no_read", o_read_data, 32'h0);
        tick();

        // Dump with ready toggling 1,0,1,...
        for (int i = 0; i < 64; i++) exp_q.push_back(model_mem[i]);
        i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
        check("dump_valid_rise", 32'(o_dump_valid), 32'd1);
        beats = 0; done_cnt = 0; held = 1'b0; cyc = 0;
        held_d = '0; held_a = '0;
        while (done_cnt == 0 && cyc < 300) begin
            i_dump_ready = (cyc % 2 == 0);
            #1;
            if (o_dump_valid) begin
                if (held) begin
                    check("dump_data_stable", o_dump_data, held_d);
                    check("dump_addr_stable", 32'(o_dump_addr), 32'(held_a));
                end
                if (i_dump_ready) begin
                    check("dump_addr", 32'(o_dump_addr), 32'(beats));
                    if (exp_q.size() > 0) exp_word = exp_q.pop_front();
                    else exp_word = 32'hFFFF_FFFF;
                    check("dump_data", o_dump_data, exp_word);
                    beats++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_d = o_dump_data;
                    held_a = o_dump_addr;
                end
            end
            tick();
            cyc++;
            if (o_dump_done) done_cnt++;
        end
        i_dump_ready = 1'b0;
        check("dump_beats", 32'(beats), 32'd64);
        repeat (3) begin
            tick();
            if (o_dump_done) done_cnt++;
        end
        check("dump_done_once", 32'(done_cnt), 32'd1);
        check("dump_valid_end", 32'(o_dump_valid), 32'd0);
        check("dump_busy_end",  32'(o_busy), 32'd0);

        // Reset in the middle of a dump.
        i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
        i_dump_ready = 1'b1;
        cyc = 0;
        while (!(o_dump_valid && o_dump_addr == 6'd10) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("dump_reach_beat10", 32'(o_dump_addr), 32'd10);
        i_reset = 1'b1;
        i_dump_ready = 1'b0;
        tick();
        check("rst_mid_dump_valid", 32'(o_dump_valid), 32'd0);
        check("rst_mid_dump_busy",  32'(o_busy), 32'd1);
        check("rst_mid_dump_addr",  32'(o_dump_addr), 32'd0);
        load_check("ld_gated_busy", 32'h8, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        i_reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick();
            cnt++;
        end
        store(32'h0, 32'hFFFFFFFF, SIZE_WORD, 1'b1);
        cnt++;
        while (o_busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("clear_restart_len", 32'(cnt), 32'd64);
        load_check("ld_w_0x0_store_dropped", 32'h0, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        load_check("ld_w_0x8_recleared",     32'h8, SIZE_WORD, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
